led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
- Parametrised column-multiplexed LED matrix driver: successor to the fixed 5-column / 50-bit scan loop.
- Holds a double-buffered frame of COLS columns × ROWS bits.
- Drives one column ground at a time, with a programmable dwell time and an anti-ghosting blanking gap between columns.
- Sits between the pattern/digit generators (write side) and the matrix pins (row_out / gnd_out).

Parameters:
- ROWS, 10, row lines per column (bits per column word).
- COLS, 5, column ground lines scanned; must be ≥ 2.
- DWELL, 1000, clk cycles each column is driven; must be ≥ 2.
- BLANK, 16, clk cycles all outputs are off between columns; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the back buffer.
- wr_col  in  $clog2(COLS)  column index to write.
- wr_data  in  ROWS  row pattern for wr_col; bit r lights row r.
- swap_req  in  1  request to swap front/back buffers at the next frame boundary.
- swap_ack  out  1  one-cycle pulse when the swap takes effect.
- row_out  out  ROWS  registered row drive, active-high.
- gnd_out  out  COLS  registered one-hot column sink enable, active-high.
- frame_start  out  1  one-cycle pulse on the first DRIVE cycle of column 0.

Behaviour:
- Reset (async assert, sync release):
  - row_out=0, gnd_out=0, swap_ack=0, frame_start=0.
  - Both buffers cleared to 0; front_sel=0; swap pending=0.
  - col=0, state=BLANK, cnt=0.
- FSM states:
  - BLANK: row_out=0, gnd_out=0, for exactly BLANK cycles; then goes to DRIVE.
  - DRIVE: gnd_out=1<<col, row_out=front[col], for exactly DWELL cycles; then goes to BLANK with col←col+1.
  - col wraps from COLS-1 to 0.
- Timing:
  - Outputs are registered. The first cycle after reset release is BLANK cycle 0; DRIVE col0 begins BLANK cycles later.
  - Frame period = COLS×(BLANK+DWELL) cycles.
  - frame_start coincides with the first DRIVE cycle of col0.
- Buffer contents:
  - row_out samples the front buffer every DRIVE cycle (not latched at column entry).
  - Mid-column front changes therefore occur only at swap.
- Writes:
  - wr_en=1 writes wr_data to back[wr_col] at the clock edge.
  - wr_col ≥ COLS: the write is ignored.
  - Writes never touch the front buffer.
- Swap handshake:
  - swap_req=1 for ≥ 1 cycle sets pending.
  - The swap executes on the clock edge ending the last DRIVE cycle of col COLS-1 (frame boundary).
  - At that edge: front_sel flips, pending clears, and swap_ack=1 for the following cycle.
  - Additional swap_req while pending: absorbed, yielding a single swap and a single ack.
  - swap_req asserted in the swap cycle itself: consumed by that swap; no second swap.
- Simultaneous write + swap: a write in the swap cycle lands in the new back buffer, i.e. the buffer that was front.
- Back-buffer contents are not copied on swap; software rewrites the full frame.
- Reset mid-frame: outputs go low immediately (async); the scan restarts from BLANK col0 and pending is dropped.
- Counters:
  - cnt width = $clog2(max(DWELL,BLANK)).
  - cnt reloads to 0 on every state change.
  - No overflow is possible.

Optional Feature:
- Macro: LED_SCAN_BRIGHTNESS_EN.
- Enabled:
  - Adds input brightness[3:0].
  - In DRIVE, row_out=front[col] only while cnt < (brightness×DWELL)>>4; otherwise row_out=0. gnd_out is unchanged.
  - brightness=0 keeps all rows dark; brightness=15 gives 15/16 duty.
  - brightness is sampled once at column entry and held for that column.
- Disabled: the port does not exist and rows are on for the full DWELL.

Test Plan (ROWS=10, COLS=5, DWELL=8, BLANK=2 unless noted):
- Reset release, no writes:
  - gnd_out sequence 00000 ×2, 00001 ×8, 00000 ×2, 00010 ×8 … wrapping after 10000.
  - row_out stays 0 throughout.
  - frame_start pulses every 50 cycles.
- Write back[0..4]=0x3FF,0x001,0x200,0x155,0x2AA, then swap_req 1 cycle:
  - swap_ack pulses exactly once, at the frame boundary.
  - From the next frame, row_out equals each value while the matching column is driven.
  - Before the swap, row_out stays 0.
- Triple swap_req pulses within one frame → exactly one swap_ack, with front_sel toggled once.
- Write with wr_col=7 → no buffer changes; the display is unchanged after swap.
- Write back[2]=0x0F0 in the exact swap cycle:
  - The displayed col2 keeps the pre-swap back value.
  - The 0x0F0 appears only after the next swap.
- Assert rst mid-DRIVE of col3:
  - gnd_out and row_out are 0 within the same cycle.
  - After release: 2 blank cycles, then col0 with all-zero data and no swap_ack.
  - (LED_SCAN_BRIGHTNESS_EN, DWELL=16, brightness=4): rows are on for 4 of 16 DRIVE cycles, while gnd_out stays on for all 16.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed LED matrix scanner: double-buffered frame, blanking gap between columns,
// buffer swap at frame boundary. Optional PWM dimming when LED_SCAN_BRIGHTNESS_EN is defined.
module led_matrix_scanner #(
  parameter int ROWS  = 10,
  parameter int COLS  = 5,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [ROWS-1:0]         wr_data,
  input  logic                    swap_req,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic                    swap_ack,
  output logic [ROWS-1:0]         row_out,
  output logic [COLS-1:0]         gnd_out,
  output logic                    frame_start
);
  localparam int IW   = $clog2(COLS);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] COL_LAST   = IW'(COLS - 1);
  localparam logic [IW:0]   COLS_W     = (IW + 1)'(COLS);

  logic [0:0]      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   col_reg, col_next;
  logic            front_sel_reg, front_sel_next;
  logic            pending_reg, pending_next;
  logic [ROWS-1:0] buf0_reg [COLS];
  logic [ROWS-1:0] buf1_reg [COLS];

  logic            last_blank, last_drive, do_swap, wr_ok, row_on;
  logic [ROWS-1:0] front_word, row_next;
  logic [COLS-1:0] col_onehot, gnd_next;

  always_comb begin
    last_blank = (state_reg == ST_BLANK) && (cnt_reg == BLANK_LAST);
    last_drive = (state_reg == ST_DRIVE) && (cnt_reg == DWELL_LAST);
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    col_next   = col_reg;
    if (last_blank) begin
      state_next = ST_DRIVE;
      cnt_next   = '0;
    end else if (last_drive) begin
      state_next = ST_BLANK;
      cnt_next   = '0;
      col_next   = (col_reg == COL_LAST) ? '0 : col_reg + 1'b1;
    end
    // A request arriving in the boundary cycle itself is consumed by this swap.
    do_swap        = last_drive && (col_reg == COL_LAST) && (pending_reg || swap_req);
    front_sel_next = front_sel_reg ^ do_swap;
    pending_next   = !do_swap && (pending_reg || swap_req);
  end

  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_onehot
      assign col_onehot[gi] = (col_next == IW'(gi));
    end
  endgenerate

`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [CW-1:0] thr_reg, thr_next;

  // Threshold is latched on column entry so a brightness change never splits a column.
  always_comb begin
    thr_next = thr_reg;
    if (last_blank) thr_next = CW'((int'(brightness) * DWELL) >> 4);
  end

  assign row_on = (cnt_next < thr_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) thr_reg <= '0;
    else     thr_reg <= thr_next;
  end
`else
  assign row_on = 1'b1;
`endif

  assign front_word = front_sel_next ? buf1_reg[col_next] : buf0_reg[col_next];

  always_comb begin
    gnd_next = '0;
    row_next = '0;
    if (state_next == ST_DRIVE) begin
      gnd_next = col_onehot;
      if (row_on) row_next = front_word;
    end
  end

  // Writes target the buffer that is back after this edge, so a write in the swap
  // cycle lands in the buffer that was front until now.
  assign wr_ok = wr_en && ({1'b0, wr_col} < COLS_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) begin
        buf0_reg[c] <= '0;
        buf1_reg[c] <= '0;
      end
    end else if (wr_ok) begin
      if (front_sel_next) buf0_reg[wr_col] <= wr_data;
      else                buf1_reg[wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_BLANK;
      cnt_reg       <= '0;
      col_reg       <= '0;
      front_sel_reg <= 1'b0;
      pending_reg   <= 1'b0;
      row_out       <= '0;
      gnd_out       <= '0;
      swap_ack      <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      col_reg       <= col_next;
      front_sel_reg <= front_sel_next;
      pending_reg   <= pending_next;
      row_out       <= row_next;
      gnd_out       <= gnd_next;
      swap_ack      <= do_swap;
      frame_start   <= last_blank && (col_reg == '0);
    end
  end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: per-cycle position model plus a queue of expected swap acks.
module tb_led_matrix_scanner;
  localparam int ROWS  = 10;
  localparam int COLS  = 5;
  localparam int BLANK = 2;
`ifdef LED_SCAN_BRIGHTNESS_EN
  localparam int DWELL = 16;
  localparam int THR   = (4 * DWELL) >> 4;
`else
  localparam int DWELL = 8;
  localparam int THR   = DWELL;
`endif
  localparam int SLOT  = BLANK + DWELL;
  localparam int FRAME = COLS * SLOT;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    wr_en = 1'b0;
  logic [$clog2(COLS)-1:0] wr_col = '0;
  logic [ROWS-1:0]         wr_data = '0;
  logic                    swap_req = 1'b0;
  logic                    swap_ack, frame_start;
  logic [ROWS-1:0]         row_out;
  logic [COLS-1:0]         gnd_out;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [3:0]              brightness = 4'd4;
`endif

  int errors = 0, checks = 0, tcyc = 0, fs_count = 0, ack_count = 0;
  logic [ROWS-1:0] bufm [2][COLS];
  int fsel = 0;
  int ack_q[$];

  always #5 clk = ~clk;

  led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_data(wr_data),
    .swap_req(swap_req),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .swap_ack(swap_ack), .row_out(row_out), .gnd_out(gnd_out), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, tcyc);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < COLS; c++) bufm[b][c] = '0;
    fsel = 0;
    ack_q.delete();
  endtask

  task automatic check_outputs();
    int p, col, o;
    logic drive, ea;
    logic [COLS-1:0] eg;
    logic [ROWS-1:0] er;
    p     = tcyc % FRAME;
    col   = p / SLOT;
    o     = p % SLOT;
    drive = (o >= BLANK);
    eg    = drive ? COLS'(1 << col) : '0;
    er    = (drive && (o - BLANK) < THR) ? bufm[fsel][col] : '0;
    ea    = (ack_q.size() > 0) && (ack_q[0] == tcyc);
    chk("gnd_out", 32'(gnd_out), 32'(eg));
    chk("row_out", 32'(row_out), 32'(er));
    chk("frame_start", 32'(frame_start), 32'(p == BLANK));
    chk("swap_ack", 32'(swap_ack), 32'(ea));
    if (ea) begin
      void'(ack_q.pop_front());
      $display("swap: ack at cycle %0d, front buffer %0d", tcyc, fsel);
    end
    if (frame_start) fs_count++;
    if (swap_ack) ack_count++;
  endtask

  task automatic model_edge();
    int p;
    p = tcyc % FRAME;
    if (swap_req && (ack_q.size() == 0 || ack_q[$] <= tcyc))
      ack_q.push_back(tcyc + (FRAME - 1 - p) + 1);
    if (ack_q.size() > 0 && ack_q[0] == tcyc + 1) fsel = 1 - fsel;
    if (wr_en && int'(wr_col) < COLS) bufm[1 - fsel][wr_col] = wr_data;
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_edge();
    tcyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic advance_to(input int target);
    int i;
    i = 0;
    while ((tcyc % FRAME) != target && i < FRAME) begin
      tick();
      i++;
    end
    if ((tcyc % FRAME) != target) begin
      checks++;
      errors++;
      $display("FAIL advance_to bound expired target=%0d", target);
    end
  endtask

  task automatic write(input int col, input logic [ROWS-1:0] data);
    wr_en = 1'b1; wr_col = ($clog2(COLS))'(col); wr_data = data;
    $display("write: col=%0d data=0x%0h cycle=%0d", col, data, tcyc);
    tick();
    wr_en = 1'b0; wr_col = '0; wr_data = '0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  initial begin
    int a0, g_on, r_on;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    chk("reset_gnd", 32'(gnd_out), 32'd0);
    chk("reset_row", 32'(row_out), 32'd0);
    chk("reset_ack", 32'(swap_ack), 32'd0);
    chk("reset_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tcyc = 0;

    // Idle scan: two frames with empty buffers
    fs_count = 0;
    run(2 * FRAME);
    chk("fs_count_two_frames", 32'(fs_count), 32'd2);

    // Load a frame, swap, check it appears only after the boundary
    write(0, 10'h3FF);
    write(1, 10'h001);
    write(2, 10'h200);
    write(3, 10'h155);
    write(4, 10'h2AA);
    pulse_swap();
    chk("row_before_swap", 32'(row_out), 32'd0);
    run(FRAME);
    advance_to(3 * SLOT + BLANK + 1);
    chk("col3_after_swap", 32'(row_out), 32'h155);
    advance_to(4 * SLOT + BLANK + 1);
    chk("col4_after_swap", 32'(row_out), 32'h2AA);
`ifdef LED_SCAN_BRIGHTNESS_EN
    advance_to(BLANK);
    g_on = 0;
    r_on = 0;
    for (int i = 0; i < DWELL; i++) begin
      if (gnd_out != '0) g_on++;
      if (row_out != '0) r_on++;
      tick();
    end
    chk("bright_gnd_cycles", 32'(g_on), 32'(DWELL));
    chk("bright_row_cycles", 32'(r_on), 32'(THR));
`endif

    // Three requests in one frame -> one swap (front returns to the empty buffer)
    a0 = ack_count;
    advance_to(5);
    pulse_swap();
    advance_to(15);
    pulse_swap();
    advance_to(25);
    pulse_swap();
    run(FRAME);
    chk("triple_req_one_ack", 32'(ack_count - a0), 32'd1);
    advance_to(SLOT + BLANK);
    chk("front_toggled_once", 32'(row_out), 32'd0);

    // Out-of-range write is ignored
    write(7, 10'h123);
    pulse_swap();
    run(FRAME);
    advance_to(BLANK + 1);
    chk("oob_write_col0", 32'(row_out), 32'h3FF);
    advance_to(2 * SLOT + BLANK + 1);
    chk("oob_write_col2", 32'(row_out), 32'h200);

    // Write in the swap cycle lands in the new back buffer
    write(0, 10'h011);
    write(1, 10'h022);
    write(2, 10'h033);
    write(3, 10'h044);
    write(4, 10'h055);
    pulse_swap();
    advance_to(FRAME - 1);
    write(2, 10'h0F0);
    advance_to(2 * SLOT + BLANK + 1);
    chk("col2_pre_swap_back", 32'(row_out), 32'h033);
    pulse_swap();
    run(FRAME);
    advance_to(2 * SLOT + BLANK + 1);
    chk("col2_after_next_swap", 32'(row_out), 32'h0F0);

    // Reset mid-DRIVE of col3 with a swap pending
    advance_to(1);
    pulse_swap();
    advance_to(3 * SLOT + BLANK + 3);
    chk("pre_reset_gnd", 32'(gnd_out), 32'h08);
    chk("pre_reset_row", 32'(row_out), 32'h155);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_gnd", 32'(gnd_out), 32'd0);
    chk("async_reset_row", 32'(row_out), 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    tcyc = 0;
    a0 = ack_count;
    run(BLANK);
    chk("post_reset_col0_gnd", 32'(gnd_out), 32'h01);
    chk("post_reset_col0_row", 32'(row_out), 32'd0);
    run(2 * FRAME);
    chk("post_reset_no_ack", 32'(ack_count - a0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
